// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Column drive patterns and a helper that decodes an active-low row sample.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_t;

    localparam logic [3:0] COL_DRIVE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    typedef struct packed {
        logic       single;
        logic [1:0] idx;
    } row_dec_t;

    // Exactly one low bit yields single=1; all-ones or multi-low yields single=0.
    function automatic row_dec_t decode_row(input logic [3:0] r);
        row_dec_t d;
        d.single = 1'b0;
        d.idx    = 2'd0;
        case (r)
            4'b1110: begin d.single = 1'b1; d.idx = 2'd0; end
            4'b1101: begin d.single = 1'b1; d.idx = 2'd1; end
            4'b1011: begin d.single = 1'b1; d.idx = 2'd2; end
            4'b0111: begin d.single = 1'b1; d.idx = 2'd3; end
            default: begin d.single = 1'b0; d.idx = 2'd0; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Generic two-flop synchronizer with a parameterised reset value.
// Each bit is synchronized independently; the lines are sampled only after settling.
module sync2 #(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    meta_q[gi] <= RST_VAL[gi];
                    sync_q[gi] <= RST_VAL[gi];
                end else begin
                    meta_q[gi] <= d[gi];
                    sync_q[gi] <= meta_q[gi];
                end
            end
        end
    endgenerate

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: walks the columns, debounces a single-row press
// in the frozen column and reports it as {row_idx, col_idx} with a one-cycle strobe.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES    = 4,
    parameter int DEBOUNCE_SAMPLES = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int DW = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_SAMPLES - 1);

    logic [3:0]    row_sync;

    state_t        state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [DW-1:0] dcnt_q,      dcnt_d;
    logic [1:0]    col_idx_q,   col_idx_d;
    logic [1:0]    row_idx_q,   row_idx_d;
    logic [3:0]    col_q,       col_d;
    logic [3:0]    key_code_q,  key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          key_held_q,  key_held_d;

    logic          sample;
    logic          col_adv;
    logic          hit;
    row_dec_t      dec;

    sync2 #(
        .WIDTH  (4),
        .RST_VAL(4'b1111)
    ) u_row_sync (
        .clock  (clock),
        .reset_n(reset_n),
        .d      (row),
        .q      (row_sync)
    );

    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        row_idx_d   = row_idx_q;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        key_valid_d = 1'b0;
        col_adv     = 1'b0;

        sample = (cnt_q == SETTLE_LAST);
        dec    = decode_row(row_sync);
        hit    = dec.single && (dec.idx == row_idx_q);

        case (state_q)
            SCAN: begin
                if (sample) begin
                    if (dec.single) begin
                        row_idx_d = dec.idx;
                        if (DEBOUNCE_SAMPLES == 1) begin
                            state_d     = HELD;
                            dcnt_d      = '0;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            key_code_d  = {dec.idx, col_idx_q};
                        end else begin
                            state_d = DEBOUNCE;
                            dcnt_d  = DW'(1);
                        end
                    end else begin
                        col_adv = 1'b1;
                    end
                end
            end

            DEBOUNCE: begin
                if (sample) begin
                    if (hit) begin
                        if (dcnt_q == DB_LAST) begin
                            state_d     = HELD;
                            dcnt_d      = '0;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            key_code_d  = {row_idx_q, col_idx_q};
                        end else begin
                            dcnt_d = dcnt_q + DW'(1);
                        end
                    end else begin
                        state_d = SCAN;
                        dcnt_d  = '0;
                        col_adv = 1'b1;
                    end
                end
            end

            HELD: begin
                // dcnt_q now counts consecutive release samples
                if (sample) begin
                    if (hit) begin
                        dcnt_d = '0;
                    end else if (dcnt_q == DB_LAST) begin
                        state_d    = SCAN;
                        dcnt_d     = '0;
                        key_held_d = 1'b0;
                        col_adv    = 1'b1;
                    end else begin
                        dcnt_d = dcnt_q + DW'(1);
                    end
                end
            end

            default: begin
                state_d = SCAN;
                dcnt_d  = '0;
            end
        endcase

        col_idx_d = col_adv ? (col_idx_q + 2'd1) : col_idx_q;
        cnt_d     = (sample || col_adv) ? '0 : (cnt_q + CW'(1));
        col_d     = COL_DRIVE[col_idx_d];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= SCAN;
            cnt_q       <= '0;
            dcnt_q      <= '0;
            col_idx_q   <= 2'd0;
            row_idx_q   <= 2'd0;
            col_q       <= 4'b1110;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dcnt_q      <= dcnt_d;
            col_idx_q   <= col_idx_d;
            row_idx_q   <= row_idx_d;
            col_q       <= col_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule
